// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment receive path: active-low segment
// patterns (abcdefgh, bit 7 = a, bit 0 = dp), symbol codes and sample helpers.
package seven_seg_pkg;

   // Hex digits, dp dark (bit 0 = 1)
   localparam logic [7:0] PAT_0 = 8'b00000011;
   localparam logic [7:0] PAT_1 = 8'b10011111;
   localparam logic [7:0] PAT_2 = 8'b00100101;
   localparam logic [7:0] PAT_3 = 8'b00001101;
   localparam logic [7:0] PAT_4 = 8'b10011001;
   localparam logic [7:0] PAT_5 = 8'b01001001;
   localparam logic [7:0] PAT_6 = 8'b01000001;
   localparam logic [7:0] PAT_7 = 8'b00011111;
   localparam logic [7:0] PAT_8 = 8'b00000001;
   localparam logic [7:0] PAT_9 = 8'b00001001;
   localparam logic [7:0] PAT_A = 8'b00010001;
   localparam logic [7:0] PAT_B = 8'b11000001;
   localparam logic [7:0] PAT_C = 8'b01100011;
   localparam logic [7:0] PAT_D = 8'b10000101;
   localparam logic [7:0] PAT_E = 8'b01100001;
   localparam logic [7:0] PAT_F = 8'b01110001;

   // Letters; C and E share the hex shapes, I shares the shape of 1
   localparam logic [7:0] PAT_LET_C = PAT_C;
   localparam logic [7:0] PAT_LET_E = PAT_E;
   localparam logic [7:0] PAT_H     = 8'b11010001;
   localparam logic [7:0] PAT_I     = PAT_1;
   localparam logic [7:0] PAT_P     = 8'b00110001;
   localparam logic [7:0] PAT_BLANK = 8'b11111111;

   localparam logic [4:0] SYM_BLANK   = 5'h10;
   localparam logic [4:0] SYM_H       = 5'h11;
   localparam logic [4:0] SYM_P       = 5'h12;
   localparam logic [4:0] SYM_UNKNOWN = 5'h1F;

   typedef enum logic [1:0] {
      CLS_IDLE,
      CLS_SINGLE,
      CLS_MULTI
   } sample_cls_e;

   // Classify a sampled digit-enable word by how many enables are active (low)
   function automatic sample_cls_e classify(input logic [3:0] dig);
      case ($countones(~dig))
         0:       return CLS_IDLE;
         1:       return CLS_SINGLE;
         default: return CLS_MULTI;
      endcase
   endfunction

   // Index of the active-low enable; only meaningful for a SINGLE sample
   function automatic logic [1:0] dig_pos(input logic [3:0] dig);
      logic [1:0] p;
      p = 2'd0;
      for (int i = 0; i < 4; i++)
         if (!dig[i]) p = 2'(i);
      return p;
   endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Bus between the multiplexed display lines and the capture monitor.
interface seven_seg_capture_if;
   logic [7:0]  abcdefgh;
   logic [3:0]  digit;
   logic [19:0] sym;
   logic [3:0]  dp;
   logic [3:0]  valid;
   logic        update;
   logic        collision;

   modport master (
      output abcdefgh, digit,
      input  sym, dp, valid, update, collision
   );

   modport slave (
      input  abcdefgh, digit,
      output sym, dp, valid, update, collision
   );
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational map of an active-low a..g pattern to a 5-bit symbol code.
// The dp bit is not part of the input; unknown shapes give SYM_UNKNOWN.
module seven_seg_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [4:0] code
);

   // Pattern lookup; the letter I has the same shape as 1 and so shares code 1
   always_comb begin
      code = SYM_UNKNOWN;
      case (seg_n)
         PAT_0[7:1]:     code = 5'h00;
         PAT_I[7:1]:     code = 5'h01;
         PAT_2[7:1]:     code = 5'h02;
         PAT_3[7:1]:     code = 5'h03;
         PAT_4[7:1]:     code = 5'h04;
         PAT_5[7:1]:     code = 5'h05;
         PAT_6[7:1]:     code = 5'h06;
         PAT_7[7:1]:     code = 5'h07;
         PAT_8[7:1]:     code = 5'h08;
         PAT_9[7:1]:     code = 5'h09;
         PAT_A[7:1]:     code = 5'h0A;
         PAT_B[7:1]:     code = 5'h0B;
         PAT_LET_C[7:1]: code = 5'h0C;
         PAT_D[7:1]:     code = 5'h0D;
         PAT_LET_E[7:1]: code = 5'h0E;
         PAT_F[7:1]:     code = 5'h0F;
         PAT_H[7:1]:     code = SYM_H;
         PAT_P[7:1]:     code = SYM_P;
         PAT_BLANK[7:1]: code = SYM_BLANK;
         default:        code = SYM_UNKNOWN;
      endcase
   end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive-side monitor for the multiplexed 7-segment bus. A single-digit
// pattern must be seen for STABLE_CYCLES identical samples before it is
// decoded and latched into its position; one capture per stable run.
module seven_seg_capture
   import seven_seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4   // legal 2..255
)
(
   input  logic               clk,
   input  logic               reset_n,
   seven_seg_capture_if.slave bus
);

   localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0] RUN_CAP = 8'(STABLE_CYCLES - 1);

   logic [7:0]       s_seg, p_seg;
   logic [3:0]       s_dig, p_dig;
   logic [7:0]       run_cnt, run_nxt;
   sample_cls_e      cls;
   logic             same, capture, changed, new_dp;
   logic [1:0]       pos;
   logic [4:0]       dec_code;
   logic [3:0][4:0]  sym_q;
   logic [3:0]       dp_q, valid_q;
   logic             update_q, collision_q;

   assign cls    = classify(s_dig);
   assign pos    = dig_pos(s_dig);
   assign same   = ({s_seg, s_dig} == {p_seg, p_dig});
   assign new_dp = ~s_seg[0];

   seven_seg_decode u_dec (
      .seg_n (s_seg[7:1]),
      .code  (dec_code)
   );

   assign changed = !valid_q[pos] || (sym_q[pos] != dec_code) || (dp_q[pos] != new_dp);

   // Input sampling plus one-deep history used for the stability compare
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_seg <= 8'hFF;
         s_dig <= 4'hF;
         p_seg <= 8'hFF;
         p_dig <= 4'hF;
      end else begin
         s_seg <= bus.abcdefgh;
         s_dig <= bus.digit;
         p_seg <= s_seg;
         p_dig <= s_dig;
      end
   end

   // Run length of identical SINGLE samples; capture on the step to the limit
   always_comb begin
      run_nxt = 8'd0;
      capture = 1'b0;
      if (cls == CLS_SINGLE) begin
         if (!same)
            run_nxt = 8'd1;
         else if (run_cnt < RUN_MAX)
            run_nxt = run_cnt + 8'd1;
         else
            run_nxt = run_cnt;
         capture = same && (run_cnt == RUN_CAP);
      end
   end

   // Run counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) run_cnt <= 8'd0;
      else          run_cnt <= run_nxt;
   end

   // Per-position symbol store and status flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sym_q       <= {4{SYM_BLANK}};
         dp_q        <= 4'h0;
         valid_q     <= 4'h0;
         update_q    <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         if (capture) begin
            sym_q[pos]   <= dec_code;
            dp_q[pos]    <= new_dp;
            valid_q[pos] <= 1'b1;
         end
         update_q    <= capture && changed;
         collision_q <= (cls == CLS_MULTI);
      end
   end

   assign bus.sym       = sym_q;
   assign bus.dp        = dp_q;
   assign bus.valid     = valid_q;
   assign bus.update    = update_q;
   assign bus.collision = collision_q;

endmodule
